// File: rtl/pool_ser_if.sv
// Pooled-frame capture port and word-stream port of the pool serializer.
// slave: serializer side (accepts frames, drives the stream); master: its peer.
interface pool_ser_if #(
    parameter int IP_DATA_WIDTH = 8,
    parameter int RESULT_WIDTH  = 2
);
    localparam int DW       = 2 * IP_DATA_WIDTH;
    localparam int NUM_ELEM = RESULT_WIDTH * RESULT_WIDTH;
    localparam int IDX_W    = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;

    logic                             frame_valid;
    logic                             frame_ready;
    logic [NUM_ELEM-1:0][DW-1:0]      frame_in;
    logic                             out_valid;
    logic                             out_ready;
    logic signed [DW-1:0]             out_data;
    logic [IDX_W-1:0]                 out_index;
    logic                             out_last;

    modport slave (
        input  frame_valid, frame_in, out_ready,
        output frame_ready, out_valid, out_data, out_index, out_last
    );

    modport master (
        output frame_valid, frame_in, out_ready,
        input  frame_ready, out_valid, out_data, out_index, out_last
    );
endinterface

// File: rtl/pool_serializer.sv
// Captures a whole pooled frame in one cycle and streams it word by word
// (row-major) over valid/ready, with no bubble between back-to-back frames.
// Ports: clk, rst (async, active-high), bus (pool_ser_if.slave: frame_valid/
// frame_ready/frame_in in, out_valid/out_ready/out_data/out_index/out_last
// out), frame_count (completed frames, wraps).
// Option: define POOL_SER_RELU_EN to zero negative words at capture.
module pool_serializer #(
    parameter int IP_DATA_WIDTH = 8,
    parameter int RESULT_WIDTH  = 2,
    parameter int NUM_ELEM      = RESULT_WIDTH * RESULT_WIDTH,
    parameter int IDX_W         = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    pool_ser_if.slave        bus,
    output logic [CNT_W-1:0] frame_count
);
    localparam int DW = 2 * IP_DATA_WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                      state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [NUM_ELEM-1:0][DW-1:0] buf_q, buf_d;

    logic sending;
    logic last;
    logic accept;
    logic beat;

    assign sending = (state_q == SEND);
    assign last    = sending && (idx_q == LAST_IDX);
    assign beat    = sending && bus.out_ready;

    // Ready is forced low during reset so nothing is captured while the
    // buffer is being cleared.
    assign bus.frame_ready = !rst && (!sending || (last && bus.out_ready));
    assign accept          = bus.frame_valid && bus.frame_ready;

    assign bus.out_valid = sending;
    assign bus.out_data  = sending ? buf_q[idx_q] : '0;
    assign bus.out_index = idx_q;
    assign bus.out_last  = last;
    assign frame_count   = cnt_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (beat) begin
            if (last) begin
                idx_d   = '0;
                cnt_d   = cnt_q + 1'b1;
                state_d = IDLE;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
        // A capture on the last beat overrides the return to IDLE.
        if (accept) begin
            state_d = SEND;
            idx_d   = '0;
        end
    end

    always_comb begin
        buf_d = buf_q;
        if (accept) begin
            for (int i = 0; i < NUM_ELEM; i++) begin
`ifdef POOL_SER_RELU_EN
                buf_d[i] = bus.frame_in[i][DW-1] ? '0 : bus.frame_in[i];
`else
                buf_d[i] = bus.frame_in[i];
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end
endmodule

// File: tb/tb_pool_serializer.sv
// Directed bench for pool_serializer: 2x2 frames, 2-bit frame counter.
// Covers streaming, backpressure, back-to-back, busy ignore, reset, wrap.
module tb_pool_serializer;
    logic       clk;
    logic       rst;
    logic [1:0] fc;

    int checks   = 0;
    int failures = 0;

    pool_ser_if #(.IP_DATA_WIDTH(8), .RESULT_WIDTH(2)) bus ();

    pool_serializer #(
        .IP_DATA_WIDTH(8),
        .RESULT_WIDTH (2),
        .CNT_W        (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .frame_count(fc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int r(input int v);
`ifdef POOL_SER_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [63:0] mk(input int a, input int b,
                                       input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    int fa [4] = '{5, -3, 7, 32767};
    int fb [4] = '{1, 2, 3, 4};

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input string tag, input int k, input int d);
        @(negedge clk);
        chk({tag, ".v"}, 32'(bus.out_valid), 1);
        chk({tag, ".i"}, 32'(bus.out_index), k);
        chk({tag, ".d"}, bus.out_data, r(d));
        chk({tag, ".l"}, 32'(bus.out_last), (k == 3) ? 1 : 0);
    endtask

    task automatic idle_chk(input string tag, input int cnt);
        @(negedge clk);
        chk({tag, ".v"}, 32'(bus.out_valid), 0);
        chk({tag, ".fc"}, 32'(fc), cnt);
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        bus.frame_valid = 1'b0;
        bus.out_ready   = 1'b0;
        bus.frame_in    = '0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic load(input int f [4]);
        bus.frame_in    = mk(f[0], f[1], f[2], f[3]);
        bus.frame_valid = 1'b1;
    endtask

    initial begin
        rst             = 1'b1;
        bus.frame_valid = 1'b0;
        bus.out_ready   = 1'b0;
        bus.frame_in    = '0;
        cyc();
        @(negedge clk);
        chk("rst.v",  32'(bus.out_valid), 0);
        chk("rst.d",  bus.out_data, 0);
        chk("rst.i",  32'(bus.out_index), 0);
        chk("rst.l",  32'(bus.out_last), 0);
        chk("rst.fc", 32'(fc), 0);
        chk("rst.fr", 32'(bus.frame_ready), 0);
        cyc();
        rst = 1'b0;

        // 1: plain stream, one word per cycle
        load(fa);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("t1.fr", 32'(bus.frame_ready), 1);
        cyc();
        bus.frame_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            beat($sformatf("t1.b%0d", k), k, fa[k]);
            if (k == 0) chk("t1.fc0", 32'(fc), 0);
            cyc();
        end
        idle_chk("t1.end", 1);

        // 2: backpressure at index 1
        do_reset();
        load(fa);
        bus.out_ready = 1'b1;
        cyc();
        bus.frame_valid = 1'b0;
        beat("t2.b0", 0, fa[0]);
        cyc();
        bus.out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            beat($sformatf("t2.s%0d", s), 1, fa[1]);
            cyc();
        end
        bus.out_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            beat($sformatf("t2.b%0d", k), k, fa[k]);
            cyc();
        end
        idle_chk("t2.end", 1);

        // 3: back-to-back frames, no gap
        do_reset();
        load(fa);
        bus.out_ready = 1'b1;
        cyc();
        load(fb);
        for (int k = 0; k < 4; k++) begin
            beat($sformatf("t3.a%0d", k), k, fa[k]);
            chk($sformatf("t3.fr%0d", k), 32'(bus.frame_ready),
                (k == 3) ? 1 : 0);
            cyc();
        end
        bus.frame_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            beat($sformatf("t3.b%0d", k), k, fb[k]);
            cyc();
        end
        idle_chk("t3.end", 2);

        // 4: frame offered while busy is ignored
        do_reset();
        load(fa);
        bus.out_ready = 1'b1;
        cyc();
        bus.frame_valid = 1'b0;
        beat("t4.b0", 0, fa[0]);
        cyc();
        beat("t4.b1", 1, fa[1]);
        cyc();
        bus.frame_in    = mk(9, 9, 9, 9);
        bus.frame_valid = 1'b1;
        beat("t4.b2", 2, fa[2]);
        chk("t4.fr", 32'(bus.frame_ready), 0);
        cyc();
        bus.frame_valid = 1'b0;
        beat("t4.b3", 3, fa[3]);
        cyc();
        idle_chk("t4.e0", 1);
        cyc();
        idle_chk("t4.e1", 1);

        // 5: async reset mid-frame
        do_reset();
        load(fa);
        bus.out_ready = 1'b1;
        cyc();
        bus.frame_valid = 1'b0;
        beat("t5.b0", 0, fa[0]);
        cyc();
        beat("t5.b1", 1, fa[1]);
        cyc();
        beat("t5.b2", 2, fa[2]);
        #2;
        rst = 1'b1;
        #1;
        chk("t5.v",  32'(bus.out_valid), 0);
        chk("t5.d",  bus.out_data, 0);
        chk("t5.i",  32'(bus.out_index), 0);
        chk("t5.l",  32'(bus.out_last), 0);
        chk("t5.fr", 32'(bus.frame_ready), 0);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("t5.fr1", 32'(bus.frame_ready), 1);
        chk("t5.v1",  32'(bus.out_valid), 0);
        cyc();
        load(fb);
        cyc();
        bus.frame_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            beat($sformatf("t5.n%0d", k), k, fb[k]);
            cyc();
        end
        idle_chk("t5.end", 1);

        // 6: 2-bit counter wraps 1,2,3,0,1
        do_reset();
        bus.out_ready = 1'b1;
        for (int f = 0; f < 5; f++) begin
            load(fb);
            cyc();
            bus.frame_valid = 1'b0;
            for (int k = 0; k < 4; k++) begin
                beat($sformatf("t6.f%0d.b%0d", f, k), k, fb[k]);
                cyc();
            end
            idle_chk($sformatf("t6.f%0d", f), (f + 1) % 4);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
